// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared owner and transfer-width encodings for the memory bus arbiter
package bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam int STARVE_W = 8;

    // Saturating run-length increment; the counter never passes the DMA run limit.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                    input logic [STARVE_W-1:0] limit);
        return (cnt < limit) ? cnt + 8'd1 : limit;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection between CPU and DMA for an idle bus
module arb_pick
    import bus_pkg::*;
#(
    parameter int DMA_MAX_RUN = 4
) (
    input  logic                cpu_req,
    input  logic                dma_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output owner_t              winner
);

    localparam logic [STARVE_W-1:0] MAX_RUN = STARVE_W'(DMA_MAX_RUN);

    // DMA has priority until it has completed MAX_RUN transfers with the CPU waiting.
    always_comb begin
        winner = OWN_NONE;
        if (dma_req && (starve_cnt < MAX_RUN)) begin
            winner = OWN_DMA;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the system memory bus between the CPU and the DMA engine
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int DMA_MAX_RUN = 4
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_width,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ok,

    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_width,
    input  logic        dma_read,
    input  logic        dma_write,
    output logic [31:0] dma_rdata,
    output logic        dma_ok,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok,

    output logic [1:0]  owner
);

    localparam logic [STARVE_W-1:0] MAX_RUN = STARVE_W'(DMA_MAX_RUN);

    owner_t              state;
    owner_t              winner;
    owner_t              sel;
    logic [STARVE_W-1:0] starve_cnt;
    logic                cpu_req;
    logic                dma_req;

    assign cpu_req = cpu_read | cpu_write;
    assign dma_req = dma_read | dma_write;
    assign owner   = state;

    arb_pick #(
        .DMA_MAX_RUN (DMA_MAX_RUN)
    ) u_arb_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .starve_cnt (starve_cnt),
        .winner     (winner)
    );

    // An idle bus forwards the arbitration winner in the same cycle; reset blanks everything.
    always_comb begin
        sel = OWN_NONE;
        if (rstn) begin
            sel = (state == OWN_NONE) ? winner : state;
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_width = W_BYTE;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (sel)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_width = cpu_width;
                mem_read  = cpu_read;
                mem_write = cpu_write & ~cpu_read;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_width = dma_width;
                mem_read  = dma_read;
                mem_write = dma_write & ~dma_read;
            end
            default: ;
        endcase
    end

    assign cpu_ok    = mem_ok && (sel == OWN_CPU);
    assign dma_ok    = mem_ok && (sel == OWN_DMA);
    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= OWN_NONE;
        end else begin
            case (state)
                OWN_NONE: begin
                    if (winner != OWN_NONE && !mem_ok) begin
                        state <= winner;
                    end
                end
                OWN_CPU, OWN_DMA: begin
                    if (mem_ok) begin
                        state <= OWN_NONE;
                    end
                end
                default: state <= OWN_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (cpu_ok) begin
            starve_cnt <= '0;
        end else if (dma_ok && cpu_req) begin
            starve_cnt <= sat_inc(starve_cnt, MAX_RUN);
        end else if (state == OWN_NONE && !cpu_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_width;
    logic        cpu_read, cpu_write, cpu_ok;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [1:0]  dma_width;
    logic        dma_read, dma_write, dma_ok;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read, mem_write, mem_ok;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.DMA_MAX_RUN(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_width (cpu_width),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_ok    (cpu_ok),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_width (dma_width),
        .dma_read  (dma_read),
        .dma_write (dma_write),
        .dma_rdata (dma_rdata),
        .dma_ok    (dma_ok),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_width (mem_width),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata),
        .mem_ok    (mem_ok),
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        dma_read  = 1'b0;
        dma_write = 1'b0;
        mem_ok    = 1'b0;
    endtask

    // Expected grant pattern with both requesting and 1-cycle mem_ok: 1 = DMA, 0 = CPU.
    logic [9:0] grant_exp;

    initial begin
        grant_exp = 10'b1111011110;
        rstn      = 1'b0;
        cpu_addr  = 32'd0; cpu_wdata = 32'd0; cpu_width = 2'd0;
        dma_addr  = 32'd0; dma_wdata = 32'd0; dma_width = 2'd0;
        mem_rdata = 32'd0;
        idle_inputs();
        cpu_read  = 1'b1;
        cpu_addr  = 32'h1234_5678;
        #2;
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        step();
        step();
        rstn = 1'b1;
        idle_inputs();

        // CPU-only word read, mem_ok on the third cycle
        step();
        cpu_read = 1'b1; cpu_addr = 32'h0800_0000; cpu_width = 2'd2;
        settle();
        check("t1_c1_read", 32'(mem_read), 32'd1);
        check("t1_c1_addr", mem_addr, 32'h0800_0000);
        check("t1_c1_width", 32'(mem_width), 32'd2);
        check("t1_c1_owner", 32'(owner), 32'd0);
        check("t1_c1_ok", 32'(cpu_ok), 32'd0);
        step();
        settle();
        check("t1_c2_read", 32'(mem_read), 32'd1);
        check("t1_c2_owner", 32'(owner), 32'd1);
        check("t1_c2_ok", 32'(cpu_ok), 32'd0);
        step();
        mem_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        check("t1_c3_read", 32'(mem_read), 32'd1);
        check("t1_c3_owner", 32'(owner), 32'd1);
        check("t1_c3_ok", 32'(cpu_ok), 32'd1);
        check("t1_c3_dma_ok", 32'(dma_ok), 32'd0);
        check("t1_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
        step();
        idle_inputs();
        settle();
        check("t1_end_owner", 32'(owner), 32'd0);
        check("t1_end_read", 32'(mem_read), 32'd0);

        // simultaneous requests in an idle cycle: DMA first, CPU right after
        step();
        dma_write = 1'b1; dma_addr = 32'h0300_0000; dma_wdata = 32'hA5A5_0001; dma_width = 2'd2;
        cpu_read  = 1'b1; cpu_addr = 32'h0800_0004;
        mem_ok    = 1'b1;
        settle();
        check("t2_d_write", 32'(mem_write), 32'd1);
        check("t2_d_read", 32'(mem_read), 32'd0);
        check("t2_d_addr", mem_addr, 32'h0300_0000);
        check("t2_d_wdata", mem_wdata, 32'hA5A5_0001);
        check("t2_d_ok", 32'(dma_ok), 32'd1);
        check("t2_d_cpu_ok", 32'(cpu_ok), 32'd0);
        step();
        dma_write = 1'b0; mem_ok = 1'b0;
        settle();
        check("t2_c_owner", 32'(owner), 32'd0);
        check("t2_c_addr", mem_addr, 32'h0800_0004);
        check("t2_c_read", 32'(mem_read), 32'd1);
        mem_ok = 1'b1;
        #1;
        check("t2_c_ok", 32'(cpu_ok), 32'd1);
        step();
        idle_inputs();

        // both requesting continuously with single-cycle completions
        step();
        dma_read = 1'b1; dma_addr = 32'h0300_0100;
        cpu_read = 1'b1; cpu_addr = 32'h0800_0100;
        mem_ok   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("t3_dma_ok_%0d", i), 32'(dma_ok), 32'(grant_exp[9-i]));
            check($sformatf("t3_cpu_ok_%0d", i), 32'(cpu_ok), 32'(!grant_exp[9-i]));
            check($sformatf("t3_addr_%0d", i), mem_addr,
                  grant_exp[9-i] ? 32'h0300_0100 : 32'h0800_0100);
            step();
        end
        idle_inputs();

        // DMA holds the bus through a long transfer while the CPU waits
        step();
        dma_read = 1'b1; dma_addr = 32'h0300_0010; dma_width = 2'd1;
        settle();
        check("t4_c1_addr", mem_addr, 32'h0300_0010);
        step();
        cpu_read = 1'b1; cpu_addr = 32'h0800_0008; cpu_width = 2'd0;
        for (int i = 2; i <= 5; i++) begin
            settle();
            check($sformatf("t4_c%0d_addr", i), mem_addr, 32'h0300_0010);
            check($sformatf("t4_c%0d_owner", i), 32'(owner), 32'd2);
            check($sformatf("t4_c%0d_cpu_ok", i), 32'(cpu_ok), 32'd0);
            step();
        end
        mem_ok = 1'b1;
        settle();
        check("t4_c6_dma_ok", 32'(dma_ok), 32'd1);
        check("t4_c6_cpu_ok", 32'(cpu_ok), 32'd0);
        step();
        dma_read = 1'b0; mem_ok = 1'b0;
        settle();
        check("t4_c7_owner", 32'(owner), 32'd0);
        check("t4_c7_addr", mem_addr, 32'h0800_0008);
        check("t4_c7_width", 32'(mem_width), 32'd0);
        step();
        settle();
        check("t4_c8_owner", 32'(owner), 32'd1);
        mem_ok = 1'b1;
        #1;
        check("t4_c8_ok", 32'(cpu_ok), 32'd1);
        step();
        idle_inputs();

        // asynchronous reset in the middle of a CPU write
        step();
        cpu_write = 1'b1; cpu_addr = 32'h0800_0010; cpu_wdata = 32'h1111_2222; cpu_width = 2'd2;
        step();
        settle();
        check("t5_pre_owner", 32'(owner), 32'd1);
        check("t5_pre_write", 32'(mem_write), 32'd1);
        rstn   = 1'b0;
        mem_ok = 1'b1;
        #1;
        check("t5_rst_owner", 32'(owner), 32'd0);
        check("t5_rst_write", 32'(mem_write), 32'd0);
        check("t5_rst_addr", mem_addr, 32'd0);
        check("t5_rst_wdata", mem_wdata, 32'd0);
        check("t5_rst_ok", 32'(cpu_ok), 32'd0);
        step();
        rstn   = 1'b1;
        mem_ok = 1'b0;
        settle();
        check("t5_rel_owner", 32'(owner), 32'd0);
        check("t5_rel_write", 32'(mem_write), 32'd1);
        check("t5_rel_wdata", mem_wdata, 32'h1111_2222);
        step();
        mem_ok = 1'b1;
        settle();
        check("t5_rel_ok", 32'(cpu_ok), 32'd1);
        step();
        idle_inputs();

        // spurious mem_ok on an idle bus, then read+write strobes together
        step();
        mem_ok = 1'b1;
        settle();
        check("t6_sp_cpu_ok", 32'(cpu_ok), 32'd0);
        check("t6_sp_dma_ok", 32'(dma_ok), 32'd0);
        check("t6_sp_read", 32'(mem_read), 32'd0);
        step();
        mem_ok = 1'b0;
        settle();
        check("t6_sp_owner", 32'(owner), 32'd0);
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'h0800_0020;
        #1;
        check("t6_rw_read", 32'(mem_read), 32'd1);
        check("t6_rw_write", 32'(mem_write), 32'd0);
        step();
        settle();
        check("t6_rw_owner", 32'(owner), 32'd1);
        mem_ok = 1'b1;
        #1;
        check("t6_rw_ok", 32'(cpu_ok), 32'd1);
        step();
        idle_inputs();
        settle();
        check("t6_end_owner", 32'(owner), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter that shares the single system memory bus between the ARMv4T CPU and the DMA engine. Sits between the CPU's memory port, the DMA master port and the memory/bus decoder. When the bus is idle it forwards a request in the same cycle. It holds ownership until `mem_ok`, gives DMA fixed priority, and bounds CPU starvation with a run-length counter.

## Interface
- `DMA_MAX_RUN`, default 4: consecutive DMA completions allowed while the CPU is waiting; range 1–255.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cpu_addr` in 32: CPU address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_width` in 2: CPU transfer size; 0 byte, 1 halfword, 2 word.
- `cpu_read` in 1: CPU read request.
- `cpu_write` in 1: CPU write request.
- `cpu_rdata` out 32: read data to CPU.
- `cpu_ok` out 1: CPU transfer complete.
- `dma_addr`, `dma_wdata`, `dma_width`, `dma_read`, `dma_write`, `dma_rdata`, `dma_ok`: same widths and meanings, for the DMA port.
- `mem_addr` out 32: address to the bus decoder.
- `mem_wdata` out 32: write data to the bus decoder.
- `mem_width` out 2: transfer size to the bus decoder.
- `mem_read` out 1: read strobe to the bus decoder.
- `mem_write` out 1: write strobe to the bus decoder.
- `mem_rdata` in 32: read data from the bus decoder.
- `mem_ok` in 1: transfer complete from the bus decoder.
- `owner` out 2: registered owner; 0 none, 1 CPU, 2 DMA.

## Operation
- A requester is requesting when `x_read|x_write`. If both strobes are set, the read wins and the write strobe is not forwarded.
- Requesters hold address, data, width and strobes stable until their `x_ok` is high. They may change them only in the cycle after `x_ok`.
- State register `owner` is one of NONE, CPU or DMA.
- Selected source:
  - NONE: the combinational winner of arbitration.
  - CPU or DMA: the registered owner.
- Arbitration in NONE:
  - DMA wins if `dma_req` and `starve_cnt < DMA_MAX_RUN`.
  - Otherwise CPU wins if `cpu_req`.
  - Otherwise DMA wins if `dma_req`.
  - Otherwise there is no winner.
- The selected source's addr, wdata, width, read and write drive `mem_*`. With no source selected, all `mem_*` outputs are 0.
- `mem_ok` is routed only to the selected source's `x_ok`. `mem_rdata` goes to both `x_rdata`; only the source seeing `x_ok` may sample it.
- Transitions:
  - NONE stays NONE if there is no winner or the winner sees `mem_ok` in the same cycle. Otherwise NONE goes to the winner.
  - CPU or DMA returns to NONE on `mem_ok`; otherwise it holds.
- Ownership is never preempted. A held transfer completes regardless of new requests.
- `starve_cnt` is 8 bits, saturating at `DMA_MAX_RUN`:
  - increments on each DMA completion while `cpu_req` is high;
  - clears on any CPU completion;
  - clears when `cpu_req` is low in NONE.

## Timing
- Reset values: `owner`=0 and `starve_cnt`=0. While `rstn`=0, `mem_read`, `mem_write`, `cpu_ok` and `dma_ok` are forced to 0, and `mem_addr`/`mem_wdata`/`mem_width` are 0.
- Reset asserted mid-transfer aborts the transfer. No `x_ok` is generated, and after release arbitration restarts in NONE.
- Idle-bus latency is 0 cycles: a request in NONE drives `mem_*` in the same cycle.
- A single-cycle `mem_ok` completes a transfer in the request cycle.
- Back-to-back transfers have no bubble. The cycle after `mem_ok` is NONE and arbitrates immediately.
- With both requesting continuously, the grant pattern is exactly `DMA_MAX_RUN` DMA transfers, then 1 CPU transfer, repeating.
- A CPU request arriving while DMA owns the bus waits at most (`DMA_MAX_RUN`+1) DMA transfers.
- `mem_ok` while no source is selected is ignored.
- Combinational paths: `x_req`→`mem_*` and `mem_ok`→`x_ok`. Registered: `owner` and `starve_cnt`.

## Structure
- Shared package `bus_pkg`:
  - owner encodings OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2;
  - width encodings W_BYTE=2'd0, W_HALF=2'd1, W_WORD=2'd2.
- One sub-module, `arb_pick`: purely combinational winner selection from `cpu_req`, `dma_req`, `starve_cnt` and `DMA_MAX_RUN`. FSM, counter and muxing stay in the top module.

## Test plan
- CPU-only word read, `cpu_addr`=0x08000000, `mem_ok` on 3rd cycle: `mem_read`=1 for 3 cycles, `owner`=1 for cycles 2–3, `cpu_ok` only in cycle 3, `cpu_rdata`=`mem_rdata`.
- Both request in the same idle cycle (DMA write 0x03000000, CPU read 0x08000004): DMA is forwarded first, `mem_write`=1. The CPU is forwarded the cycle after DMA's `mem_ok`.
- Both requesting continuously with `DMA_MAX_RUN`=4 and 1-cycle `mem_ok`: grant sequence D,D,D,D,C,D,D,D,D,C. `cpu_ok` never seen by DMA, nor `dma_ok` by CPU.
- DMA owns the bus with `mem_ok` held low 5 cycles and a CPU request arriving in cycle 2: `mem_addr` stays at `dma_addr` until `mem_ok`. The CPU is granted the next cycle.
- `rstn` pulsed low mid-CPU transfer: `mem_read`=0 and `owner`=0 immediately (asynchronous), no `cpu_ok`. The transfer restarts after release.
- `cpu_read`=`cpu_write`=1 and a spurious `mem_ok` while idle: only `mem_read` is driven. The spurious `mem_ok` causes no `x_ok` and no state change.
